// File: rtl/fm_sb_pkg.sv
// Shared types and helpers for the floating-monitor spybuffer channel.
// Latency: none (package only).
// Backpressure: none (package only).
package fm_sb_pkg;

  typedef enum logic [1:0] {
    SPY     = 2'b00,
    FREEZE  = 2'b01,
    PB_ONCE = 2'b10,
    PB_LOOP = 2'b11
  } pb_mode_t;

  localparam int axi_dw        = 32;
  localparam int pb_mode_width = 2;

  // Lanes per stored entry: 1 when the pipeline word fits in one register
  // word, otherwise the lane count rounded up to an even number.
  function automatic int ceil_even_ratio(input int tp_dw, input int lane_dw);
    int r;
    if (tp_dw <= lane_dw) return 1;
    r = (tp_dw + lane_dw - 1) / lane_dw;
    if ((r % 2) != 0) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fm_sb_channel_ram.sv
// Simple dual-port read-first spy memory: port A write + playback read, port B register read.
// Latency: 1 cycle on both read ports (registered output).
// Backpressure: none; reads and writes are accepted every cycle.
module fm_sb_ram #(
  parameter int DW = 64,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Non-blocking update gives read-first: same-cycle reads see the old word.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/fm_sb_channel.sv
// One spybuffer channel: spy capture, freeze, playback once/loop, lane-wise register reads. Optional trigger: FM_SB_TRIGGER_EN.
// Latency: pass-through 1 cycle, playback 2 cycles after mode entry, register read 2 cycles.
// Backpressure: none; in_vld is always accepted, outputs are valid-only, reads are fully pipelined.
module fm_sb_channel
  import fm_sb_pkg::*;
#(
  parameter  int TP_DW      = 51,
  parameter  int AXI_DW     = axi_dw,
  parameter  int DEPTH_LOG2 = 10,
  localparam int R          = ceil_even_ratio(TP_DW, AXI_DW),
  localparam int SB_DW      = R * AXI_DW,
  localparam int AW         = DEPTH_LOG2 + $clog2(R)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [pb_mode_width-1:0] pb_mode,
  input  logic [DEPTH_LOG2-1:0]    pb_len,
  input  logic [TP_DW-1:0]         in_data,
  input  logic                     in_vld,
  output logic [TP_DW-1:0]         out_data,
  output logic                     out_vld,
  input  logic                     axi_rd_en,
  input  logic [AW-1:0]            axi_rd_addr,
  output logic [AXI_DW-1:0]        axi_rd_data,
  output logic                     axi_rd_vld,
  output logic [DEPTH_LOG2-1:0]    wr_ptr,
  output logic                     wrapped,
  output logic                     pb_done
`ifdef FM_SB_TRIGGER_EN
  ,
  input  logic                     trig,
  input  logic [DEPTH_LOG2-1:0]    post_trig
`endif
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [DEPTH_LOG2-1:0] LAST_ENTRY = '1;

  pb_mode_t mode, mode_q;
  logic first_q, entry, spy, is_pb, frozen_eff, do_write;
  logic [DEPTH_LOG2-1:0] wr_addr, rd_ptr, rd_addr, pb_last, ram_a_addr, axi_entry;
  logic [LW-1:0] axi_lane, lane_d1;
  logic running, issue, is_last, pb_vld_d1, last_d1, last_d2, rd_vld_d1;
  logic [SB_DW-1:0] wdata, ram_a_q, ram_b_q;
  logic [AXI_DW-1:0] lane_word;
  logic unused_pad;

  assign mode    = pb_mode_t'(pb_mode);
  assign entry   = first_q || (mode != mode_q);
  assign spy     = (mode == SPY);
  assign is_pb   = (mode == PB_ONCE) || (mode == PB_LOOP);

  // Spy entry restarts at entry 0 in the same cycle; playback entry restarts at 0.
  assign wr_addr  = entry ? '0 : wr_ptr;
  assign do_write = spy && in_vld && !frozen_eff;
  assign rd_addr  = entry ? '0 : rd_ptr;
  assign pb_last  = pb_len - 1'b1;
  assign issue    = is_pb && (entry || running) && (pb_len != '0);
  assign is_last  = (rd_addr >= pb_last);
  assign ram_a_addr = is_pb ? rd_addr : wr_addr;
  assign unused_pad = ^ram_a_q;

  // Register address is {entry, lane}; with a single lane the whole address is the entry.
  generate
    if (R > 1) begin : g_lane
      assign axi_entry = axi_rd_addr[AW-1 -: DEPTH_LOG2];
      assign axi_lane  = axi_rd_addr[LW-1:0];
    end else begin : g_nolane
      assign axi_entry = axi_rd_addr;
      assign axi_lane  = '0;
    end
  endgenerate

  // Zero-pad the pipeline word up to the stored entry width.
  always_comb begin
    wdata = '0;
    wdata[TP_DW-1:0] = in_data;
  end

  // Pick the requested lane out of the read entry; lanes past R read as zero.
  always_comb begin
    lane_word = '0;
    for (int l = 0; l < R; l++) begin
      if (int'(lane_d1) == l) lane_word = ram_b_q[l*AXI_DW +: AXI_DW];
    end
  end

  fm_sb_ram #(.DW(SB_DW), .AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .a_we    (do_write),
    .a_addr  (ram_a_addr),
    .a_wdata (wdata),
    .a_rdata (ram_a_q),
    .b_addr  (axi_entry),
    .b_rdata (ram_b_q)
  );

  // Track the previous mode; the first cycle out of reset counts as a spy entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= SPY;
      first_q <= 1'b1;
    end else begin
      mode_q  <= mode;
      first_q <= 1'b0;
    end
  end

  // Write pointer and wrap flag, cleared on spy entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else begin
      if (spy && entry) begin
        wr_ptr  <= '0;
        wrapped <= 1'b0;
      end
      if (do_write) begin
        wr_ptr <= wr_addr + 1'b1;
        if (wr_addr == LAST_ENTRY) wrapped <= 1'b1;
      end
    end
  end

  // Playback read pointer: one entry per cycle, wraps in loop mode, stops in once mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b0;
      if (issue) begin
        if (is_last) begin
          rd_ptr  <= '0;
          running <= (mode == PB_LOOP);
        end else begin
          rd_ptr  <= rd_addr + 1'b1;
          running <= 1'b1;
        end
      end
    end
  end

  // Playback pipe tags; anything in flight across a mode change is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_vld_d1 <= 1'b0;
      last_d1   <= 1'b0;
      last_d2   <= 1'b0;
    end else begin
      pb_vld_d1 <= issue;
      last_d1   <= issue && is_last && (mode == PB_ONCE);
      last_d2   <= last_d1 && !entry;
    end
  end

  // Output register: replayed words in playback, one-cycle pass-through otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (is_pb) begin
      out_vld <= pb_vld_d1 && !entry;
      if (pb_vld_d1) out_data <= ram_a_q[TP_DW-1:0];
    end else begin
      out_vld  <= in_vld;
      out_data <= in_data;
    end
  end

  // Done flag for playback-once: set as the last word leaves, held until the mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_done <= 1'b0;
    end else if (mode != PB_ONCE) begin
      pb_done <= 1'b0;
    end else if (entry) begin
      pb_done <= (pb_len == '0);
    end else if (last_d2) begin
      pb_done <= 1'b1;
    end
  end

  // Register read pipe: RAM stage then lane-select stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_d1   <= 1'b0;
      lane_d1     <= '0;
      axi_rd_vld  <= 1'b0;
      axi_rd_data <= '0;
    end else begin
      rd_vld_d1  <= axi_rd_en;
      lane_d1    <= axi_lane;
      axi_rd_vld <= rd_vld_d1;
      if (rd_vld_d1) axi_rd_data <= lane_word;
    end
  end

`ifdef FM_SB_TRIGGER_EN
  logic trig_armed, trig_frozen, armed_eff;
  logic [DEPTH_LOG2-1:0] trig_cnt;

  assign armed_eff  = trig_armed && !entry;
  assign frozen_eff = trig_frozen && !entry;

  // Post-trigger countdown: the trigger-cycle write is kept, then post_trig more writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_armed  <= 1'b0;
      trig_frozen <= 1'b0;
      trig_cnt    <= '0;
    end else if (spy) begin
      if (entry) begin
        trig_armed  <= 1'b0;
        trig_frozen <= 1'b0;
      end
      if (trig && !armed_eff) begin
        trig_armed  <= 1'b1;
        trig_cnt    <= post_trig;
        trig_frozen <= (post_trig == '0);
      end else if (armed_eff && do_write) begin
        trig_cnt <= trig_cnt - 1'b1;
        if (trig_cnt == DEPTH_LOG2'(1)) trig_frozen <= 1'b1;
      end
    end
  end
`else
  assign frozen_eff = 1'b0;
`endif

endmodule
